// File: rtl/dac_stream_decimator.sv
// Integrate-and-dump decimator turning per-cycle L/R DAC codes into PCM pairs on a valid/ready
// handshake. Define DAC_DEC_PEAK_EN to add the peak_l/peak_r level meters and peak_clr.
module dac_stream_decimator #(
  parameter int unsigned DECIM_LOG2 = 8,
  parameter int unsigned IN_W       = 6
) (
  input  logic                       clk21m,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [IN_W-1:0]            dac_l,
  input  logic [IN_W-1:0]            dac_r,
  output logic                       pcm_valid,
  input  logic                       pcm_ready,
  output logic [IN_W+DECIM_LOG2-1:0] pcm_l,
  output logic [IN_W+DECIM_LOG2-1:0] pcm_r,
  output logic                       overrun,
  input  logic                       clr_overrun
`ifdef DAC_DEC_PEAK_EN
  ,
  input  logic                       peak_clr,
  output logic [IN_W-1:0]            peak_l,
  output logic [IN_W-1:0]            peak_r
`endif
);

  localparam int unsigned OUT_W = IN_W + DECIM_LOG2;

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [OUT_W-1:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]      sum_l, sum_r;
  logic [OUT_W-1:0]      pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  last, complete, drop;

  assign last     = (phase_q == {DECIM_LOG2{1'b1}});
  assign complete = enable && last;
  assign sum_l    = acc_l_q + OUT_W'(dac_l);
  assign sum_r    = acc_r_q + OUT_W'(dac_r);

  always_comb begin
    phase_d = phase_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (enable) begin
      phase_d = phase_q + 1'b1;
      acc_l_d = last ? '0 : sum_l;
      acc_r_d = last ? '0 : sum_r;
    end
  end

  // A finished window only lands if the output slot is empty or being drained this cycle.
  always_comb begin
    pcm_valid_d = pcm_valid_q;
    pcm_l_d     = pcm_l_q;
    pcm_r_d     = pcm_r_q;
    drop        = 1'b0;
    if (complete) begin
      if (!pcm_valid_q || pcm_ready) begin
        pcm_valid_d = 1'b1;
        pcm_l_d     = sum_l;
        pcm_r_d     = sum_r;
      end else begin
        drop = 1'b1;
      end
    end else if (pcm_valid_q && pcm_ready) begin
      pcm_valid_d = 1'b0;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      pcm_l_q     <= pcm_l_d;
      pcm_r_q     <= pcm_r_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_valid = pcm_valid_q;
  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;
  assign overrun   = overrun_q;

`ifdef DAC_DEC_PEAK_EN
  logic [IN_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;

  // Clearing while disabled leaves 0 since the current code is not a valid sample.
  always_comb begin
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (peak_clr) begin
      peak_l_d = enable ? dac_l : '0;
      peak_r_d = enable ? dac_r : '0;
    end else if (enable) begin
      if (dac_l > peak_l_q) peak_l_d = dac_l;
      if (dac_r > peak_r_q) peak_r_d = dac_r;
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l = peak_l_q;
  assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_dac_stream_decimator.sv
// Directed self-checking bench for dac_stream_decimator at DECIM_LOG2=8, IN_W=6.
// Peak-meter checks are included when DAC_DEC_PEAK_EN is defined.
module tb_dac_stream_decimator;

  localparam int unsigned DECIM_LOG2 = 8;
  localparam int unsigned IN_W       = 6;
  localparam int unsigned OUT_W      = IN_W + DECIM_LOG2;

  logic             clk21m = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [IN_W-1:0]  dac_l, dac_r;
  logic             pcm_valid;
  logic             pcm_ready;
  logic [OUT_W-1:0] pcm_l, pcm_r;
  logic             overrun;
  logic             clr_overrun;
`ifdef DAC_DEC_PEAK_EN
  logic             peak_clr;
  logic [IN_W-1:0]  peak_l, peak_r;
`endif

  int total = 0;
  int bad   = 0;

  dac_stream_decimator #(
    .DECIM_LOG2(DECIM_LOG2),
    .IN_W      (IN_W)
  ) dut (
    .clk21m     (clk21m),
    .reset_n    (reset_n),
    .enable     (enable),
    .dac_l      (dac_l),
    .dac_r      (dac_r),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .pcm_l      (pcm_l),
    .pcm_r      (pcm_r),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
`ifdef DAC_DEC_PEAK_EN
    ,
    .peak_clr   (peak_clr),
    .peak_l     (peak_l),
    .peak_r     (peak_r)
`endif
  );

  always #5 clk21m = ~clk21m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk21m);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    dac_l       = '0;
    dac_r       = '0;
    pcm_ready   = 1'b0;
    clr_overrun = 1'b0;
`ifdef DAC_DEC_PEAK_EN
    peak_clr    = 1'b0;
`endif
    tick(2);
    check("rst_valid", 32'(pcm_valid), 0);
    check("rst_pcm_l", 32'(pcm_l), 0);
    check("rst_pcm_r", 32'(pcm_r), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;

    // 1: full-scale left, silent right
    enable = 1'b1; pcm_ready = 1'b1; dac_l = 6'd63; dac_r = 6'd0;
    tick(255);
    check("t1_valid_early", 32'(pcm_valid), 0);
    tick(1);
    check("t1_valid", 32'(pcm_valid), 1);
    check("t1_pcm_l", 32'(pcm_l), 16128);
    check("t1_pcm_r", 32'(pcm_r), 0);
    check("t1_overrun", 32'(overrun), 0);
    enable = 1'b0;
    tick(1);
    check("t1_valid_drop", 32'(pcm_valid), 0);
    check("t1_pcm_l_hold", 32'(pcm_l), 16128);

    // 2: four back-to-back windows, pulses 256 cycles apart
    do_reset();
    enable = 1'b1; pcm_ready = 1'b1; dac_l = 6'd32; dac_r = 6'd1;
    for (int w = 0; w < 4; w++) begin
      tick(255);
      check("t2_valid_gap", 32'(pcm_valid), 0);
      tick(1);
      check("t2_valid", 32'(pcm_valid), 1);
      check("t2_pcm_l", 32'(pcm_l), 8192);
      check("t2_pcm_r", 32'(pcm_r), 256);
    end

    // 3: blocked consumer, overrun set/clear priority
    do_reset();
    enable = 1'b1; pcm_ready = 1'b0; dac_l = 6'd10; dac_r = 6'd0;
    tick(256);
    check("t3_valid_w1", 32'(pcm_valid), 1);
    check("t3_pcm_l_w1", 32'(pcm_l), 2560);
    check("t3_overrun_w1", 32'(overrun), 0);
    dac_l = 6'd20;
    tick(256);
    check("t3_pcm_l_held", 32'(pcm_l), 2560);
    check("t3_overrun_w2", 32'(overrun), 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 0);
    tick(254);
    check("t3_overrun_pre", 32'(overrun), 0);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("t3_overrun_setwins", 32'(overrun), 1);
    check("t3_pcm_l_w3", 32'(pcm_l), 2560);
    pcm_ready = 1'b1;
    tick(1);
    check("t3_valid_drain", 32'(pcm_valid), 0);
    check("t3_pcm_l_after", 32'(pcm_l), 2560);

    // 4: enable toggling; disabled-cycle codes must not count
    do_reset();
    pcm_ready = 1'b1;
    for (int i = 0; i < 511; i++) begin
      enable = (i % 2 == 1);
      dac_l  = enable ? 6'd5 : 6'd63;
      dac_r  = enable ? 6'd0 : 6'd63;
      tick(1);
    end
    check("t4_valid_early", 32'(pcm_valid), 0);
    enable = 1'b1; dac_l = 6'd5; dac_r = 6'd0;
    tick(1);
    check("t4_valid", 32'(pcm_valid), 1);
    check("t4_pcm_l", 32'(pcm_l), 1280);
    check("t4_pcm_r", 32'(pcm_r), 0);

    // 5: reset mid-window discards partial sums and clears outputs
    do_reset();
    enable = 1'b1; pcm_ready = 1'b0; dac_l = 6'd7; dac_r = 6'd3;
    tick(256);
    check("t5_pcm_l_pre", 32'(pcm_l), 1792);
    tick(100);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(pcm_valid), 0);
    check("t5_rst_pcm_l", 32'(pcm_l), 0);
    check("t5_rst_pcm_r", 32'(pcm_r), 0);
    tick(1);
    reset_n = 1'b1;
    pcm_ready = 1'b1; dac_l = 6'd9; dac_r = 6'd2;
    tick(255);
    check("t5_valid_early", 32'(pcm_valid), 0);
    tick(1);
    check("t5_valid", 32'(pcm_valid), 1);
    check("t5_pcm_l", 32'(pcm_l), 2304);
    check("t5_pcm_r", 32'(pcm_r), 512);

`ifdef DAC_DEC_PEAK_EN
    // 6: peak tracking and clear
    do_reset();
    check("t6_peak_rst", 32'(peak_l), 0);
    enable = 1'b1; dac_r = 6'd1;
    dac_l = 6'd3;  tick(1);
    dac_l = 6'd40; tick(1);
    dac_l = 6'd7;  tick(1);
    check("t6_peak_l", 32'(peak_l), 40);
    check("t6_peak_r", 32'(peak_r), 1);
    peak_clr = 1'b1; dac_l = 6'd2; dac_r = 6'd0;
    tick(1);
    peak_clr = 1'b0;
    check("t6_peak_clr_l", 32'(peak_l), 2);
    check("t6_peak_clr_r", 32'(peak_r), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
